// File: rtl/mult_share_arb.sv
// Round-robin arbiter that time-shares one external constant multiplier among
// NUM_REQ requesters and returns each product with the owning requester's id.
module mult_share_arb #(
  parameter int BIT_WIDTH = 8,
  parameter int OUT_WIDTH = BIT_WIDTH + 8,
  parameter int NUM_REQ   = 4,
  parameter int MULT_WAIT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [BIT_WIDTH-1:0]         mult_inp,
  input  logic [OUT_WIDTH-1:0]         mult_out,
  output logic                         rsp_valid,
  output logic [OUT_WIDTH-1:0]         rsp_data,
  output logic [2:0]                   rsp_id,
  input  logic                         rsp_ready,
  output logic                         busy,
  output logic [15:0]                  done_count
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t               state_q, state_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] mult_inp_q, mult_inp_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [OUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]           rsp_id_q, rsp_id_d;
  logic [15:0]          done_count_q, done_count_d;

  logic [NUM_REQ-1:0]   grant_oh;
  logic [2:0]           grant_idx;
  logic                 grant_found;
  logic [3:0]           cand;
  logic                 transfer;
  logic [BIT_WIDTH-1:0] sel_data;

  // Rotating priority search: first valid requester at or above ptr, wrapping.
  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = 4'(ptr_q) + 4'(k);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!grant_found && (cand == 4'(j)) && req_valid[j]) begin
          grant_found = 1'b1;
          grant_idx   = 3'(j);
          grant_oh[j] = 1'b1;
        end
      end
    end
  end

  assign transfer = |(req_valid & req_ready);
  assign sel_data = req_data[int'(grant_idx)*BIT_WIDTH +: BIT_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      mult_inp_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      mult_inp_q   <= mult_inp_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      done_count_q <= done_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (transfer) state_d = WAIT;
      WAIT:    if (cnt_q == 4'd1) state_d = HOLD;
      HOLD:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates that accompany each state transition.
  always_comb begin
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    mult_inp_d   = mult_inp_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    done_count_d = done_count_q;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          mult_inp_d = sel_data;
          rsp_id_d   = grant_idx;
          ptr_d      = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
          cnt_d      = 4'(MULT_WAIT);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_data_d  = mult_out;
          rsp_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          done_count_d = done_count_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) ? grant_oh : '0;
    busy      = (state_q != IDLE);
  end

  assign mult_inp   = mult_inp_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign done_count = done_count_q;

endmodule
